// File: rtl/bitwise_logic_seq.sv
// bitwise_logic_seq: multi-cycle bitwise logic unit (NOT/AND/OR/XOR/NOR/pass).
// Operands are latched on an accepted start. One CHUNK-bit slice is computed
// per clock, LSB slice first, so a narrow slice of gate logic serves any WIDTH.
// WIDTH must be an integer multiple of CHUNK.
module bitwise_logic_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [2:0]       op_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             busy_r;
  logic             done_r;

  logic             accept_s;
  logic             last_s;
  logic [CHUNK-1:0] a_slice_s;
  logic [CHUNK-1:0] b_slice_s;
  logic [CHUNK-1:0] r_slice_s;
  logic [WIDTH-1:0] result_next_s;

  // One slice of the selected bitwise operation; codes 101-111 pass a through.
  function automatic logic [CHUNK-1:0] slice_op(
    input logic [2:0]       f,
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y
  );
    logic [CHUNK-1:0] r;
    r = x;
    case (f)
      3'b000:  r = ~x;
      3'b001:  r = x & y;
      3'b010:  r = x | y;
      3'b011:  r = x ^ y;
      3'b100:  r = ~(x | y);
      default: r = x;
    endcase
    return r;
  endfunction

  assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));
  assign last_s   = (cnt_r == LAST_IDX);

  // Current slice computation and the full result with that slice merged in.
  always_comb begin
    a_slice_s     = a_r[int'(cnt_r) * CHUNK +: CHUNK];
    b_slice_s     = b_r[int'(cnt_r) * CHUNK +: CHUNK];
    r_slice_s     = slice_op(op_r, a_slice_s, b_slice_s);
    result_next_s = result_r;
    result_next_s[int'(cnt_r) * CHUNK +: CHUNK] = r_slice_s;
  end

  // Next-state logic: start only matters in IDLE/DONE; RUN ends on the last slice.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand latch, slice counter and progressive result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= '0;
      b_r      <= '0;
      op_r     <= 3'b000;
      cnt_r    <= '0;
      result_r <= '0;
      zero_r   <= 1'b0;
    end else if (accept_s) begin
      a_r      <= a;
      b_r      <= b;
      op_r     <= op;
      cnt_r    <= '0;
      result_r <= '0;
    end else if (state_r == RUN) begin
      result_r <= result_next_s;
      if (last_s) begin
        cnt_r  <= '0;
        zero_r <= (result_next_s == '0);
      end else begin
        cnt_r  <= cnt_r + CW'(1);
      end
    end
  end

  // Handshake flags registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s == RUN);
      done_r <= (state_next_s == DONE);
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign zero   = zero_r;

endmodule
